// File: rtl/word_slice_serializer_pkg.sv
// Shared types and helpers for the word slice serializer family.
// next_nonzero_idx is only referenced when SPLITTER_ZERO_SKIP_EN is defined.
package splitter_pkg;

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 8;
   localparam int unsigned MAX_N     = 64;

   typedef struct packed {
      logic       found;
      logic [5:0] idx;
   } nz_result_t;

   // Scans the nonzero-slice mask from 'from' in the given direction;
   // 'inclusive' decides whether 'from' itself is a candidate.
   function automatic nz_result_t next_nonzero_idx(
      input logic [MAX_N-1:0] mask,
      input int unsigned      n,
      input int unsigned      from,
      input logic             msb,
      input logic             inclusive
   );
      nz_result_t  r;
      int unsigned j;
      logic        in_range;
      r = '0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         j = msb ? (MAX_N - 1 - k) : k;
         if (msb) in_range = inclusive ? (j <= from) : (j < from);
         else     in_range = inclusive ? (j >= from) : (j > from);
         if (!r.found && (j < n) && in_range && mask[j]) begin
            r.found = 1'b1;
            r.idx   = 6'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/word_slice_serializer_slice_mux.sv
// Combinational slice selector: returns word[idx*SLICE +: SLICE].
module slice_mux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8,
   parameter int unsigned IDXW  = $clog2(WIDTH / SLICE)
) (
   input  logic [WIDTH-1:0] word,
   input  logic [IDXW-1:0]  idx,
   output logic [SLICE-1:0] slice
);

   localparam int unsigned N = WIDTH / SLICE;

   always_comb begin
      slice = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx == IDXW'(i)) slice = word[i*SLICE +: SLICE];
      end
   end

endmodule

// File: rtl/word_slice_serializer.sv
// Latches a WIDTH-bit word and streams it as WIDTH/SLICE slices, LSB- or MSB-first.
// Optional SPLITTER_ZERO_SKIP_EN: all-zero slices are skipped.
module word_slice_serializer
   import splitter_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic                              msb_first,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SLICE-1:0]                  out_data,
   output logic [$clog2(WIDTH/SLICE)-1:0]    out_idx,
   output logic                              out_last
);

   localparam int unsigned N    = WIDTH / SLICE;
   localparam int unsigned IDXW = $clog2(N);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  word_q, word_d;
   logic              mode_q, mode_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [IDXW-1:0]   start_idx, step_idx;
   logic              last_int;
   logic              accept, beat;

`ifdef SPLITTER_ZERO_SKIP_EN
   logic [MAX_N-1:0] mask_q, mask_in;
   nz_result_t       nz_start, nz_step;

   // An all-zero word falls back to the nominal start index and is its own last beat.
   always_comb begin
      mask_q  = '0;
      mask_in = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask_q[i]  = |word_q[i*SLICE +: SLICE];
         mask_in[i] = |in_data[i*SLICE +: SLICE];
      end
      nz_start = next_nonzero_idx(mask_in, N, msb_first ? (N - 1) : 0, msb_first, 1'b1);
      nz_step  = next_nonzero_idx(mask_q, N, 32'(idx_q), mode_q, 1'b0);
      if (nz_start.found) start_idx = IDXW'(nz_start.idx);
      else                start_idx = msb_first ? IDX_LAST : '0;
      step_idx = IDXW'(nz_step.idx);
      last_int = !nz_step.found;
   end
`else
   always_comb begin
      start_idx = msb_first ? IDX_LAST : '0;
      step_idx  = mode_q ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
      last_int  = mode_q ? (idx_q == '0) : (idx_q == IDX_LAST);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
      end
   end

   // A final beat and a new accept in the same cycle reload directly: no bubble.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      out_valid = (state_q == S_SEND);
      out_last  = out_valid && last_int;
      in_ready  = !reset && ((state_q == S_IDLE) || (out_last && out_ready));
      accept    = in_valid && in_ready;
      beat      = out_valid && out_ready;

      case (state_q)
         S_IDLE: ;
         S_SEND: begin
            if (beat) begin
               if (out_last) state_d = S_IDLE;
               else          idx_d   = step_idx;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         state_d = S_SEND;
         word_d  = in_data;
         mode_d  = msb_first;
         idx_d   = start_idx;
      end
   end

   assign out_idx = idx_q;

   slice_mux #(
      .WIDTH (WIDTH),
      .SLICE (SLICE),
      .IDXW  (IDXW)
   ) u_slice_mux (
      .word  (word_q),
      .idx   (idx_q),
      .slice (out_data)
   );

endmodule
